// File: rtl/lieat_disp_oitf_if.sv
// Dispatch <-> OITF interface.
// Bundles the allocate handshake, the long-instruction writeback (retire) strobe,
// the operand dependency query and the OITF status outputs.
//   master : dispatch / execute side (drives alloc_*, longi_wbck*, dep_*)
//   slave  : the OITF itself (drives alloc_ready, alloc_ptr, oitf_*)
interface lieat_disp_oitf_if #(
  parameter int unsigned RGIDX_SIZE = 5,
  parameter int unsigned PTR_W      = 2
);
  logic                  alloc_valid;
  logic                  alloc_ready;
  logic [RGIDX_SIZE-1:0] alloc_rd;
  logic                  alloc_rdwen;
  logic [1:0]            alloc_op;
  logic [PTR_W-1:0]      alloc_ptr;

  logic                  longi_wbck;
  logic [1:0]            longi_wbck_op;
  logic                  oitf_waw_dep;

  logic                  dep_rs1en;
  logic                  dep_rs2en;
  logic                  dep_rden;
  logic [RGIDX_SIZE-1:0] dep_rs1;
  logic [RGIDX_SIZE-1:0] dep_rs2;
  logic [RGIDX_SIZE-1:0] dep_rd;
  logic                  oitf_raw_dep;
  logic                  oitf_waw_disp;

  logic                  oitf_empty;
  logic                  oitf_full;
  logic [PTR_W:0]        oitf_count;
  logic                  oitf_err;

  modport master (
    output alloc_valid, alloc_rd, alloc_rdwen, alloc_op,
    output longi_wbck, longi_wbck_op,
    output dep_rs1en, dep_rs2en, dep_rden, dep_rs1, dep_rs2, dep_rd,
    input  alloc_ready, alloc_ptr, oitf_waw_dep, oitf_raw_dep, oitf_waw_disp,
    input  oitf_empty, oitf_full, oitf_count, oitf_err
  );

  modport slave (
    input  alloc_valid, alloc_rd, alloc_rdwen, alloc_op,
    input  longi_wbck, longi_wbck_op,
    input  dep_rs1en, dep_rs2en, dep_rden, dep_rs1, dep_rs2, dep_rd,
    output alloc_ready, alloc_ptr, oitf_waw_dep, oitf_raw_dep, oitf_waw_disp,
    output oitf_empty, oitf_full, oitf_count, oitf_err
  );
endinterface

// File: rtl/lieat_disp_oitf.sv
// Outstanding Instruction Track FIFO.
// Tracks long-latency instructions (LSU, MULDIV) in flight in the execute stage,
// in program order. Dispatch allocates an entry per long instruction; the execute
// stage retires the oldest entry on each long-instruction writeback.
// Ports:
//   clk  : clock
//   rstn : asynchronous active-low reset, discards all entries and clears oitf_err
//   bus  : lieat_disp_oitf_if.slave
//          alloc_*     allocate handshake, alloc_ptr = entry index handed out
//          longi_wbck* retire of the head entry
//          dep_*       operands of the instruction at dispatch, answered by
//                      oitf_raw_dep / oitf_waw_disp
//          oitf_waw_dep head rd also written by a younger entry (stale write)
//          oitf_empty/full/count/err status
module lieat_disp_oitf #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned RGIDX_SIZE = 5
) (
  input logic              clk,
  input logic              rstn,
  lieat_disp_oitf_if.slave bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] PtrOne = (PTR_W+1)'(1);

  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [DEPTH-1:0]      rdwen_q, rdwen_d;
  logic [RGIDX_SIZE-1:0] rd_q [DEPTH];
  logic [RGIDX_SIZE-1:0] rd_d [DEPTH];
  logic [1:0]            op_q [DEPTH];
  logic [1:0]            op_d [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [PTR_W:0]        wptr_q, wptr_d;
  logic [PTR_W:0]        rptr_q, rptr_d;
  logic                  err_q, err_d;

  logic [PTR_W-1:0] widx, ridx;
  logic             full, empty;
  logic             alloc_fire, ret_fire;
  // Entry can cause a hazard: valid, writes rd, rd is not x0.
  logic [DEPTH-1:0] live;

  assign widx  = wptr_q[PTR_W-1:0];
  assign ridx  = rptr_q[PTR_W-1:0];
  assign full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) && (widx == ridx);
  assign empty = (wptr_q == rptr_q);

  // A same-cycle retire never frees space for a same-cycle allocate.
  assign alloc_fire = bus.alloc_valid & ~full;
  assign ret_fire   = bus.longi_wbck & ~empty;

  always_comb begin
    vld_d   = vld_q;
    rdwen_d = rdwen_q;
    rd_d    = rd_q;
    op_d    = op_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    err_d   = err_q;
    if (bus.longi_wbck && empty) begin
      err_d = 1'b1;
    end
    if (ret_fire) begin
      vld_d[ridx] = 1'b0;
      rptr_d      = rptr_q + PtrOne;
      if (bus.longi_wbck_op != op_q[ridx]) begin
        err_d = 1'b1;
      end
    end
    // Not full here, so widx never aliases the retiring head.
    if (alloc_fire) begin
      vld_d[widx]   = 1'b1;
      rdwen_d[widx] = bus.alloc_rdwen;
      rd_d[widx]    = bus.alloc_rd;
      op_d[widx]    = bus.alloc_op;
      wptr_d        = wptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q   <= '0;
      rdwen_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rd_q[i] <= '0;
        op_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      err_q  <= 1'b0;
    end else begin
      vld_q   <= vld_d;
      rdwen_q <= rdwen_d;
      rd_q    <= rd_d;
      op_q    <= op_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      live[i] = vld_q[i] & rdwen_q[i] & (rd_q[i] != '0);
    end
  end

  // Hazards look only at registered state; a retiring head still reports.
  logic raw_dep, waw_disp, waw_dep;
  always_comb begin
    raw_dep  = 1'b0;
    waw_disp = 1'b0;
    waw_dep  = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (live[i]) begin
        if ((bus.dep_rs1en && (rd_q[i] == bus.dep_rs1)) ||
            (bus.dep_rs2en && (rd_q[i] == bus.dep_rs2))) begin
          raw_dep = 1'b1;
        end
        if (bus.dep_rden && (rd_q[i] == bus.dep_rd)) begin
          waw_disp = 1'b1;
        end
        if (live[ridx] && (PTR_W'(i) != ridx) && (rd_q[i] == rd_q[ridx])) begin
          waw_dep = 1'b1;
        end
      end
    end
  end

  assign bus.alloc_ready   = ~full;
  assign bus.alloc_ptr     = widx;
  assign bus.oitf_raw_dep  = raw_dep;
  assign bus.oitf_waw_disp = waw_disp;
  assign bus.oitf_waw_dep  = waw_dep;
  assign bus.oitf_empty    = empty;
  assign bus.oitf_full     = full;
  assign bus.oitf_count    = wptr_q - rptr_q;
  assign bus.oitf_err      = err_q;

endmodule

// File: doc/lieat_disp_oitf.md
Name: lieat_disp_oitf

Overview:
- Outstanding Instruction Track FIFO, located in dispatch directly upstream of the execute stage.
- Records every long-latency instruction (LSU, MULDIV) dispatched into the execute stage.
- Supplies RAW/WAW hazard flags to dispatch and the WAW flag for long-instruction writeback.
- Retires entries in order when the execute stage signals a long-instruction writeback.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- RGIDX_SIZE, 5, register index width.
- PTR_W, $clog2(DEPTH), pointer width (derived).

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- alloc_valid  input  1  dispatch requests an entry for a long instruction
- alloc_ready  output  1  entry available (= ~full)
- alloc_rd  input  RGIDX_SIZE  destination register
- alloc_rdwen  input  1  instruction writes rd
- alloc_op  input  2  unit code: 01 = LSU, 10 = MULDIV
- alloc_ptr  output  PTR_W  write pointer value given to the allocating instruction
- longi_wbck  input  1  execute stage retires the oldest long instruction this cycle
- longi_wbck_op  input  2  unit code of the retiring instruction
- oitf_waw_dep  output  1  head rd is overwritten by a younger valid entry
- dep_rs1en, dep_rs2en, dep_rden  input  1 each  operand check enables
- dep_rs1, dep_rs2, dep_rd  input  RGIDX_SIZE each  operands of the instruction being dispatched
- oitf_raw_dep  output  1  rs1 or rs2 matches an outstanding rd
- oitf_waw_disp  output  1  rd matches an outstanding rd
- oitf_empty, oitf_full  output  1 each  status
- oitf_count  output  PTR_W+1  occupied entries
- oitf_err  output  1  sticky protocol error flag

Behaviour:
- Storage: per entry, a valid bit plus rd, rdwen and op. Read and write pointers are PTR_W bits wide with an extra wrap bit.
- full: pointers equal except for the wrap bit. empty: pointers fully equal.
- Reset (async, rstn = 0): all valid bits 0, both pointers 0, oitf_err 0.
  - Resulting outputs: alloc_ready = 1, oitf_empty = 1, oitf_full = 0, oitf_count = 0, alloc_ptr = 0, all dep outputs 0.
  - A reset asserted mid-operation discards every entry.
- Allocate: when alloc_valid & alloc_ready, on the clock edge the entry at the write pointer is written with valid = 1, and the write pointer increments with wrap.
  - alloc_ptr is combinational from the current write pointer.
  - alloc_ready depends only on the registered full flag. A retire in the same cycle never frees space for a same-cycle allocate when the FIFO is full.
- Retire: when longi_wbck & ~empty, the head entry's valid bit clears and the read pointer increments.
  - If longi_wbck_op != head op, the pop still happens and oitf_err sets.
  - longi_wbck while empty: no state change, oitf_err sets.
  - oitf_err stays set until reset.
- Simultaneous allocate and retire (not full, not empty): both happen; oitf_count is unchanged.
- Allocate and retire on a single-entry FIFO: head pops, the new entry is written, and oitf_empty stays 0.
- Hazard checks: purely combinational from registered state. Entries allocated or retired in the same cycle are not reflected until the next cycle.
  - A match requires entry valid, entry rdwen = 1, entry rd != 0, and the corresponding enable set.
  - oitf_raw_dep = match on dep_rs1 OR dep_rs2 against any entry.
  - oitf_waw_disp = match on dep_rd against any entry.
  - A retiring head still reports dependencies in its retire cycle (conservative).
- oitf_waw_dep:
  - Set when the head is valid with rdwen = 1, rd != 0, and some other valid entry has rdwen = 1 and the same rd.
  - Consumed by writeback to suppress the stale regfile write.
  - 0 when empty or when only one entry is valid.
- oitf_count = write pointer − read pointer, modulo 2·DEPTH.
- Latency: allocate and retire take effect on the next clock edge. All flags reflect the new state one cycle after the handshake.

Test Plan:
- Reset, then idle → alloc_ready = 1, oitf_empty = 1, oitf_count = 0, oitf_err = 0; all dep outputs 0 for arbitrary inputs.
- Allocate 4 entries (rd = 1,2,3,4, op = 01) → oitf_full = 1 and alloc_ready = 0 after the 4th edge, oitf_count = 4. A 5th alloc_valid is ignored. alloc_ptr sequence 0,1,2,3, then it wraps to 0 after one retire.
- Entry rd = 5 outstanding; dispatch dep_rs2 = 5 with dep_rs2en = 1 → oitf_raw_dep = 1. Same case with dep_rs2en = 0 → 0. Entry rd = 0 with rdwen = 1 → never any dependency.
- Allocate rd = 7 op = 10, then rd = 7 op = 01 → oitf_waw_dep = 1. Retire with op = 10 → oitf_waw_dep = 0, oitf_count = 1, oitf_err = 0.
- Full FIFO, longi_wbck & alloc_valid in the same cycle → retire only, oitf_count 4 → 3. Next cycle the alloc succeeds and oitf_count returns to 4.
- Retire while empty, or longi_wbck_op = 01 against a head op of 10 → oitf_err = 1 and stays 1. Assert rstn = 0 mid-stream with 3 entries → oitf_count = 0 and oitf_err = 0 immediately, without waiting for a clock edge.
